// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data ports, data first; MEM_ARB_STATS_EN adds stall counters
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_dm
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       if_wait_cnt,
  output logic [31:0]       dm_wait_cnt
`endif
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic last_dm, dm_req, busy, fin, go_dm, go_if;
  always_comb begin
    dm_req = dm_read | dm_write;
    busy = state == IF_WAIT || state == DM_WAIT;
    fin = busy && cnt == CW'(1);
    go_dm = dm_req && (state == IDLE || (state == DONE && !last_dm));
    go_if = if_req && ((state == IDLE && !dm_req) || (state == DONE && last_dm));
    state_n = go_dm ? DM_WAIT : go_if ? IF_WAIT : fin ? DONE : busy ? state : IDLE;
  end
  assign stall_if = if_req & ~if_ready;
  assign stall_dm = dm_req & ~dm_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      last_dm <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_n;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (go_dm || go_if) begin
        mem_en <= 1'b1;
        mem_we <= go_dm & dm_write;
        mem_addr <= go_dm ? dm_addr : if_addr;
        mem_wdata <= dm_wdata;
        cnt <= CW'(WAIT_CYCLES);
        last_dm <= go_dm;
      end else if (busy) begin
        cnt <= cnt - CW'(1);
        if (fin) begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (state == IF_WAIT) begin
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end else begin
            dm_ready <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end
`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if_wait_cnt <= '0;
      dm_wait_cnt <= '0;
    end else begin
      if (stall_if && ~&if_wait_cnt) if_wait_cnt <= if_wait_cnt + 32'd1;
      if (stall_dm && ~&dm_wait_cnt) dm_wait_cnt <= dm_wait_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with a ready-pulse scoreboard against mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int W = 2;
  logic clk = 1'b0, rst;
  logic if_req, if_ready, dm_read, dm_write, dm_ready, mem_en, mem_we, stall_if, stall_dm;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] if_wait_cnt, dm_wait_cnt, if_base, dm_base;
`endif
  int cyc = 0, run = 0, errs = 0, checks = 0, n;
  typedef struct {logic [31:0] d; int c;} exp_t;
  exp_t if_q[$], dm_q[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
`ifdef MEM_ARB_STATS_EN
    , .if_wait_cnt(if_wait_cnt), .dm_wait_cnt(dm_wait_cnt)
`endif
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) run <= mem_en ? run + 1 : 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h8C220004;
      32'h44:  return 32'hAABBCCDD;
      32'h200: return 32'h12345678;
      default: return 32'hFFFF0000;
    endcase
  endfunction
  assign mem_rdata = (mem_en && run == W - 1) ? memval(mem_addr) : 32'hBADC0DE0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit dm, input logic [31:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    if (dm) dm_q.push_back(e);
    else if_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if_ready) begin
      if (if_q.size() == 0) chk("if_ready unexpected", 64'(cyc), 64'(-1));
      else begin
        e = if_q.pop_front();
        chk("if_rdata", 64'(if_rdata), 64'(e.d));
        chk("if_ready cycle", 64'(cyc), 64'(e.c));
      end
    end
    if (dm_ready) begin
      if (dm_q.size() == 0) chk("dm_ready unexpected", 64'(cyc), 64'(-1));
      else begin
        e = dm_q.pop_front();
        chk("dm_rdata", 64'(dm_rdata), 64'(e.d));
        chk("dm_ready cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    step(); step();
    chk("rst mem_en", 64'(mem_en), 0);
    chk("rst mem_we", 64'(mem_we), 0);
    chk("rst mem_addr", 64'(mem_addr), 0);
    chk("rst mem_wdata", 64'(mem_wdata), 0);
    chk("rst readys", 64'({if_ready, dm_ready}), 0);
    chk("rst if_rdata", 64'(if_rdata), 0);
    chk("rst dm_rdata", 64'(dm_rdata), 0);
    rst = 1'b0;
    // fetch only
    step(); n = cyc; if_req = 1'b1; if_addr = 32'h40; #1;
    chk("s1 stall_if", 64'(stall_if), 1);
    chk("s1 idle en", 64'(mem_en), 0);
    push(0, 32'h8C220004, n + 3);
    for (int k = 1; k <= W; k++) begin
      step();
      chk("s1 en", 64'(mem_en), 1);
      chk("s1 we", 64'(mem_we), 0);
      chk("s1 addr", 64'(mem_addr), 32'h40);
      chk("s1 stall_if wait", 64'(stall_if), 1);
    end
    step();
    chk("s1 en off", 64'(mem_en), 0);
    chk("s1 stall_if done", 64'(stall_if), 0);
    step(); if_req = 1'b0;
    step();
    // simultaneous fetch and data read
    step(); n = cyc;
`ifdef MEM_ARB_STATS_EN
    if_base = if_wait_cnt; dm_base = dm_wait_cnt;
`endif
    if_req = 1'b1; if_addr = 32'h44; dm_read = 1'b1; dm_addr = 32'h200; #1;
    chk("s2 stalls", 64'({stall_if, stall_dm}), 2'b11);
    push(1, 32'h12345678, n + 3);
    push(0, 32'hAABBCCDD, n + 6);
    for (int k = 1; k <= W; k++) begin
      step();
      chk("s2 dm en", 64'(mem_en), 1);
      chk("s2 dm addr", 64'(mem_addr), 32'h200);
    end
    step();
    chk("s2 done en", 64'(mem_en), 0);
    chk("s2 done stalls", 64'({stall_if, stall_dm}), 2'b10);
    step(); dm_read = 1'b0; #1;
    chk("s2 if en", 64'(mem_en), 1);
    chk("s2 if addr", 64'(mem_addr), 32'h44);
    step();
    chk("s2 if en2", 64'(mem_en), 1);
    step();
    chk("s2 if done en", 64'(mem_en), 0);
    step(); if_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
    chk("s2 if_wait_cnt", 64'(if_wait_cnt - if_base), 6);
    chk("s2 dm_wait_cnt", 64'(dm_wait_cnt - dm_base), 3);
`endif
    step();
    // data write
    step(); n = cyc; dm_write = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
    push(1, 32'h12345678, n + 3);
    for (int k = 1; k <= W; k++) begin
      step();
      chk("s3 en we", 64'({mem_en, mem_we}), 2'b11);
      chk("s3 addr", 64'(mem_addr), 32'h100);
      chk("s3 wdata", 64'(mem_wdata), 32'hDEADBEEF);
    end
    step();
    chk("s3 done en we", 64'({mem_en, mem_we}), 2'b00);
    step(); dm_write = 1'b0;
    step();
    chk("s3 dm_rdata kept", 64'(dm_rdata), 32'h12345678);
    // held fetch across DONE
    step(); n = cyc; if_req = 1'b1; if_addr = 32'h40;
    push(0, 32'h8C220004, n + 3);
    step(); step(); step(); if_addr = 32'h44;
    step();
    chk("s4 no regrant", 64'(mem_en), 0);
    push(0, 32'hAABBCCDD, n + 7);
    step();
    chk("s4 regrant en", 64'(mem_en), 1);
    chk("s4 regrant addr", 64'(mem_addr), 32'h44);
    step(); step();
    step(); if_req = 1'b0; #1;
    chk("s4 end en", 64'(mem_en), 0);
    step();
    // reset in 2nd DM_WAIT cycle
    step(); dm_read = 1'b1; dm_addr = 32'h200;
    step();
    chk("s5 en", 64'(mem_en), 1);
    step(); rst = 1'b1; dm_read = 1'b0;
    step();
    chk("s5 en we", 64'({mem_en, mem_we}), 2'b00);
    chk("s5 readys", 64'({if_ready, dm_ready}), 0);
    chk("s5 addr", 64'(mem_addr), 0);
    chk("s5 wdata", 64'(mem_wdata), 0);
    chk("s5 if_rdata", 64'(if_rdata), 0);
    chk("s5 dm_rdata", 64'(dm_rdata), 0);
    rst = 1'b0;
    step();
    chk("s5 idle en", 64'(mem_en), 0);
    chk("s5 dm_ready", 64'(dm_ready), 0);
    step(); step();
    chk("if_q drained", 64'(if_q.size()), 0);
    chk("dm_q drained", 64'(dm_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing one single-ported, fixed-latency memory between the instruction-fetch stage and the MEM stage of the pipelined MIPS core. It grants one access at a time and counts out the memory wait states. It returns read data through per-port ready pulses and drives stall outputs that the hazard logic ORs into PC/IF-ID write-enable and bubble insertion. Data accesses take priority over fetch, because the MEM-stage instruction is older.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 2, memory access latency in cycles; legal range 1..15
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1
- if_ready  out  1  one-cycle fetch-complete pulse
- dm_read  in  1  data read request; held until dm_ready
- dm_write  in  1  data write request; held until dm_ready; never asserted together with dm_read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data; valid while dm_ready=1
- dm_ready  out  1  one-cycle data-complete pulse
- mem_en  out  1  memory access active
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the WAIT_CYCLES-th consecutive cycle of mem_en
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_dm  out  1  (dm_read|dm_write) & ~dm_ready (combinational)

## Operation
- States: IDLE, IF_WAIT, DM_WAIT, DONE.
- IDLE behaviour:
  - If dm_req=dm_read|dm_write is high, go to DM_WAIT.
  - Otherwise, if if_req is high, go to IF_WAIT.
  - Otherwise, stay in IDLE.
- On entering either WAIT state:
  - Register mem_addr, mem_wdata and mem_we (mem_we = dm_write; 0 for fetch).
  - Set mem_en=1.
  - Load the counter cnt with WAIT_CYCLES. cnt is $clog2(WAIT_CYCLES+1) bits wide.
- In each WAIT state:
  - mem_en, mem_we, mem_addr and mem_wdata are held stable.
  - cnt decrements by 1 each cycle.
  - In the cycle where cnt==1, capture mem_rdata into that port's rdata register (reads only), set that port's ready to 1, clear mem_en and mem_we, and go to DONE.
- DONE: the ready pulse is high for exactly this cycle.
  - The port just served still shows its stale request and must not be regranted in this cycle.
  - The other port, if requesting, is granted directly: DONE goes to its WAIT state.
  - Otherwise go to IDLE.
- Writes pulse dm_ready but leave dm_rdata unchanged.
- if_rdata and dm_rdata hold their last captured value between accesses.
- A request that drops before ready is a protocol violation; the behaviour is unspecified and the bench must not test it.

## Timing
- Reset values: state=IDLE, cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0.
- Request seen in IDLE at cycle t:
  - mem_en is high for cycles t+1 through t+WAIT_CYCLES.
  - ready is high at cycle t+WAIT_CYCLES+1.
- Best-case back-to-back accesses, other port granted from DONE: one access every WAIT_CYCLES+1 cycles.
- Simultaneous if_req and dm_req in IDLE: data is served first. Fetch is granted from the DONE cycle of the data access.
- Same-port back-to-back requests always pass through IDLE, which adds one cycle.
- Reset asserted mid-access: at the next edge mem_en/mem_we drop, the state returns to IDLE and no ready pulse is produced. An in-flight write may be partial; this is accepted.

## Configuration
- MEM_ARB_STATS_EN defined: adds outputs if_wait_cnt and dm_wait_cnt (32 bits each).
  - Each increments on every cycle in which the matching stall_* output is high.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- MEM_ARB_STATS_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- WAIT_CYCLES=2, fetch only, if_addr=0x40, memory returns 0x8C220004 -> mem_en high for 2 cycles, if_ready=1 and if_rdata=0x8C220004 on the 3rd cycle after the request, stall_if high during cycles 0-2.
- if_req and dm_read at the same cycle -> DM_WAIT first; dm_ready at t+3; fetch mem_en starts at t+4; if_ready at t+6.
- dm_write addr 0x100 data 0xDEADBEEF -> mem_we=1 with stable addr/data for exactly WAIT_CYCLES cycles; dm_ready pulses; dm_rdata unchanged.
- Held fetch request across DONE with no data request -> no regrant in DONE; the next fetch mem_en starts 2 cycles after ready.
- rst asserted in the 2nd cycle of DM_WAIT -> mem_en=0 next cycle, no dm_ready, and all outputs at their reset values.
- MEM_ARB_STATS_EN: scenario 2 -> dm_wait_cnt=3, if_wait_cnt=6.
